// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide unit.
package div_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN    = 32'h8000_0000;

    // Encoding matches funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFinish
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift {rem,quo} left and conditionally subtract.
module div_restoring_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_shifted;
    logic [XLEN:0] trial;

    // rem < divisor always holds, so the shifted value fits XLEN+1 bits and a
    // negative trial always shows up in the top bit.
    always_comb begin
        rem_shifted = {rem, quo[XLEN-1]};
        trial       = rem_shifted - {1'b0, divisor};
        if (trial[XLEN]) begin
            rem_next = rem_shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// with the same start/done/use handshake as the iterative multiplier.
module divider_iterative
    import div_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startD,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            done,
    output logic            div_use
);

    localparam int unsigned     CntW     = $clog2(XLEN) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] AllOnes  = '1;
    localparam logic [XLEN-1:0] IntMin   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            special_q, special_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    div_op_e         op_in;
    logic            in_signed, in_rem, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix;

    div_restoring_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_next(rem_step),
        .quo_next(quo_step)
    );

    // Operand conditioning at accept time.
    always_comb begin
        op_in     = div_op_e'(div_opcode);
        in_signed = op_is_signed(op_in);
        in_rem    = op_is_rem(op_in);
        a_neg     = in_signed & operand1[XLEN-1];
        b_neg     = in_signed & operand2[XLEN-1];
        abs_a     = a_neg ? -operand1 : operand1;
        abs_b     = b_neg ? -operand2 : operand2;
        div_zero  = (operand2 == '0);
        overflow  = in_signed && (operand1 == IntMin) && (operand2 == AllOnes);
        if (div_zero) begin
            special_res = in_rem ? operand1 : AllOnes;
        end else begin
            special_res = in_rem ? '0 : IntMin;
        end
        quo_fix = quo_neg_q ? -quo_q : quo_q;
        rem_fix = rem_neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        special_d = special_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        div_use   = 1'b1;

        unique case (state_q)
            StIdle: begin
                div_use = startD;
                if (startD) begin
                    op_d      = op_in;
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    dvs_d     = abs_b;
                    cnt_d     = '0;
                    special_d = div_zero | overflow;
                    if (div_zero || overflow) begin
                        // Special result is parked in the quotient register.
                        quo_d   = special_res;
                        state_d = StFinish;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (special_q) begin
                    result_d = quo_q;
                end else begin
                    result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            op_q      <= OpDiv;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            special_q <= special_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result_divide = result_q;
    assign done          = done_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: arithmetic reference model plus
// directed vectors with hand-computed results.
module tb_divider_iterative;
    import div_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            startD = 1'b0;
    logic [1:0]      div_opcode = 2'b00;
    logic [XLEN-1:0] operand1 = '0;
    logic [XLEN-1:0] operand2 = '0;
    logic [XLEN-1:0] result_divide;
    logic            done;
    logic            div_use;

    int checks = 0;
    int errors = 0;

    divider_iterative #(
        .XLEN(XLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .startD       (startD),
        .div_opcode   (div_opcode),
        .operand1     (operand1),
        .operand2     (operand2),
        .result_divide(result_divide),
        .done         (done),
        .div_use      (div_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        return (b == 0) || (!op[0] && a == INT_MIN && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V divide semantics via plain 64-bit arithmetic (truncating division).
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q, r;
        longint      sa, sb;
        if (b == 0) begin
            q = DIV_ZERO_Q;
            r = a;
        end else if (op[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            q = INT_MIN;
            r = 0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return op[1] ? r : q;
    endfunction

    // Model: tracks when the unit is busy and what it must present, edge by edge.
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [31:0] m_pend = 0;
    logic [31:0] m_result = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy   = 0;
            m_done   = 0;
            m_result = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 0;
                    m_done   = 1;
                    m_result = m_pend;
                end
            end else if (startD) begin
                m_pend = ref_result(div_opcode, operand1, operand2);
                m_left = is_special(div_opcode, operand1, operand2) ? 1 : XLEN + 1;
                m_busy = 1;
            end
        end
        #1;
        if (rst) begin
            check("model done", {31'b0, done}, {31'b0, m_done});
            check("model result", result_divide, m_result);
        end
    end

    always @(negedge clk) begin
        if (rst) check("model div_use", {31'b0, div_use}, {31'b0, (m_busy ? 1'b1 : startD)});
    end

    // All driver activity happens 2 time units after a rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        startD     = 1'b1;
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        @(posedge clk);
        #2;
        startD = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit ok;
        lat = 0;
        ok  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            lat++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done timeout: got no done expected done within 40 edges");
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(posedge clk);
        #2;
        issue(op, a, b);
        wait_done(lat);
        check(name, result_divide, exp);
        check({name, " latency"}, lat, exp_lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return INT_MIN;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #2;
        check("reset result", result_divide, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset div_use", {31'b0, div_use}, 32'h0);
        rst = 1'b1;

        check_op("DIVU 100/7", OpDivu, 32'd100, 32'd7, 32'd14, 33);
        check("div_use in done cycle", {31'b0, div_use}, 32'h0);
        check_op("REMU 100/7", OpRemu, 32'd100, 32'd7, 32'd2, 33);
        check_op("DIV -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        check_op("REM -7/2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        check_op("DIV 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        check_op("REM 7/-2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        check_op("DIVU 5/0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        check_op("REM 5/0", OpRem, 32'd5, 32'd0, 32'd5, 1);
        check_op("DIV ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        check_op("REM ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        check_op("DIV 0/5", OpDiv, 32'd0, 32'd5, 32'd0, 33);
        check_op("DIV INT_MIN/2", OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        // A second request pulsed mid-calculation must be ignored.
        @(posedge clk);
        #2;
        issue(OpDivu, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #2;
        startD     = 1'b1;
        div_opcode = OpRem;
        operand1   = 32'd7;
        operand2   = 32'd0;
        @(posedge clk);
        #2;
        startD = 1'b0;
        wait_done(lat);
        check("ignored mid-CALC start", result_divide, 32'd100);
        check("ignored start latency", lat, 27);

        // Back-to-back: new request in the done cycle.
        issue(OpDivu, 32'hFFFF_FFFF, 32'd3);
        wait_done(lat);
        check("back-to-back DIVU", result_divide, 32'h5555_5555);
        check("back-to-back latency", lat, 33);

        // Asynchronous reset at counter 15.
        @(posedge clk);
        #2;
        issue(OpDivu, 32'hFFFF, 32'h10);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async reset result", result_divide, 32'h0);
        check("async reset done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        check_op("DIVU max/1 after reset", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 1200; i++) begin
            @(posedge clk);
            #2;
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done(lat);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
